spi_controller: RTL and testbench
=================================

Name: spi_controller

Overview:
SPI mode-0 initiator that drives the board's SPI register-file target. It issues fixed 16-bit frames: bit 15 is the R/W flag (1 = write), bits 14:8 are a 7-bit address, and bits 7:0 are data, sent MSB first.
Commands arrive on a valid/ready interface. Read-back data sampled on CIPO during the data phase is returned on a one-cycle response strobe.
SCLK is derived from clk by a half-period counter. It is slow enough for a target that resynchronises SCLK, nCS and COPI through 2-FF synchronisers.

Parameters:
HALF_PERIOD, 4, clk cycles per SCLK half-period; minimum 2.
GAP_CYCLES, 8, clk cycles nCS is held high after a frame before the next command is accepted; minimum 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write frame, 0 = read frame
cmd_addr  input  7  register address
cmd_wdata  input  8  write data
rsp_valid  output  1  one-cycle pulse at end of each frame
rsp_rdata  output  8  CIPO bits sampled in data phase; valid when rsp_valid
nCS  output  1  chip select, active low, registered
SCLK  output  1  serial clock, idle low, registered
COPI  output  1  serial data out, registered
CIPO  input  1  serial data in

Behaviour:
- Reset (asynchronous, any state):
  - nCS=1, SCLK=0, COPI=0.
  - rsp_valid=0, rsp_rdata=0x00.
  - FSM returns to IDLE, so cmd_ready=1 after reset.
  - A frame in progress is abandoned; no rsp_valid is issued for it.
- Acceptance:
  - In the accept cycle, latch the 16-bit shift word {cmd_write, cmd_addr, cmd_write ? cmd_wdata : 8'h00}.
  - Input changes after acceptance have no effect.
  - cmd_valid is ignored outside IDLE.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP:
  - Entered the cycle after acceptance: nCS=0, SCLK=0, COPI=bit15.
  - Lasts HALF_PERIOD cycles.
- SHIFT, 16 bits, index b=15..0; each bit has a high phase then a low phase:
  - High phase: SCLK=1 for HALF_PERIOD cycles. On entry (the rising edge), CIPO is sampled into the read shifter when b<=7.
  - Low phase: SCLK=0. In the cycle SCLK falls, COPI advances to bit b-1.
  - The low phase after bit 0 is HOLD.
- HOLD: HALF_PERIOD cycles with SCLK=0, nCS=0; COPI keeps bit0.
- Frame timing:
  - nCS is low for exactly 33*HALF_PERIOD cycles.
  - Exactly 16 SCLK rising edges occur per frame.
  - COPI is stable for HALF_PERIOD cycles before and after every rising edge.
- GAP:
  - Entry cycle: nCS=1, COPI=0, rsp_valid=1 for that one cycle, rsp_rdata updated from the read shifter.
  - GAP lasts GAP_CYCLES cycles, then IDLE.
  - nCS is therefore high for GAP_CYCLES+1 cycles between back-to-back frames.
- rsp_rdata holds its value until the next rsp_valid. It is updated on write frames too, since capture is full duplex.
- The CIPO sample order is MSB first: the first data-phase rising edge gives rdata[7].
- Counters:
  - The half-period counter is wide enough for max(HALF_PERIOD, GAP_CYCLES)-1.
  - The bit counter is 5 bits.
  - No wrap-around occurs beyond 16 bits.
- Only write frames with addr<=0x08 are acted on by the target. The controller does not filter addresses and transmits any 7-bit address.

Test Plan:
- Write, addr 0x04, data 0xA5, HALF_PERIOD=4 -> COPI word captured on SCLK rising edges = 0x84A5. nCS low 132 cycles. 16 SCLK rising edges. One rsp_valid.
- Read, addr 0x02, CIPO model drives 0x3C MSB-first on the falling edges of bits 8..15 -> COPI word 0x0200. rsp_rdata=0x3C with rsp_valid.
- cmd_valid held high with two queued writes, GAP_CYCLES=8 -> nCS high exactly 9 cycles between frames. cmd_ready=0 throughout each frame. Both frames are bit-exact.
- Change cmd_addr/cmd_wdata and pulse cmd_valid mid-frame -> the transmitted word is unchanged and no second frame starts.
- Assert rst_n=0 during bit 10 -> nCS=1, SCLK=0, COPI=0 immediately (asynchronous). No rsp_valid. cmd_ready=1 after release. The next write of 0x00/0xFF is transmitted correctly.
- HALF_PERIOD=2 with a behavioural model of the 2-FF-synchronising target: write 0x08 data 0x07, then read 0x08 -> the target's divider register = 0x7 and the read frame completes with COPI word 0x0800.

Source files
------------

// File: rtl/spi_controller.sv
// SPI mode-0 initiator issuing fixed 16-bit {R/W, addr[6:0], data[7:0]} frames, MSB first.
// CIPO is captured full duplex during the data phase and returned on a one-cycle response strobe.
module spi_controller #(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI,
    input  logic       CIPO
);
    localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HP_LOAD  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       bit_idx;
    logic [15:0]      tx_word;
    logic [7:0]       rx_shift;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            tx_word   <= '0;
            rx_shift  <= '0;
            nCS       <= 1'b1;
            SCLK      <= 1'b0;
            COPI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        tx_word  <= {cmd_write, cmd_addr, cmd_write ? cmd_wdata : 8'h00};
                        nCS      <= 1'b0;
                        SCLK     <= 1'b0;
                        COPI     <= cmd_write;
                        cnt      <= HP_LOAD;
                        bit_idx  <= 5'd15;
                        rx_shift <= 8'h00;
                        state    <= SETUP;
                    end
                end
                // Both end in a rising edge; bit_idx already names the bit going high.
                SETUP, SHIFT_LO: begin
                    if (cnt == '0) begin
                        SCLK  <= 1'b1;
                        cnt   <= HP_LOAD;
                        state <= SHIFT_HI;
                        if (bit_idx <= 5'd7)
                            rx_shift <= {rx_shift[6:0], CIPO};
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (cnt == '0) begin
                        SCLK <= 1'b0;
                        cnt  <= HP_LOAD;
                        if (bit_idx == 5'd0) begin
                            state <= HOLD;
                        end else begin
                            COPI    <= tx_word[14];
                            tx_word <= {tx_word[14:0], 1'b0};
                            bit_idx <= bit_idx - 5'd1;
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        nCS       <= 1'b1;
                        COPI      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rx_shift;
                        cnt       <= GAP_LOAD;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a frame monitor/CIPO target on a HALF_PERIOD=4 instance and a
// 2-FF-synchronising register-file target on a HALF_PERIOD=2 instance.
module tb_spi_controller;
    localparam int HP  = 4;
    localparam int GAP = 8;

    logic clk, rst_n;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata, rsp_rdata;
    logic rsp_valid, nCS, SCLK, COPI, cipo;

    logic b_valid, b_ready, b_write, b_rsp_valid, b_ncs, b_sclk, b_copi, b_cipo;
    logic [6:0] b_addr;
    logic [7:0] b_wdata, b_rsp_rdata;

    spi_controller #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .nCS(nCS), .SCLK(SCLK),
        .COPI(COPI), .CIPO(cipo)
    );

    spi_controller #(.HALF_PERIOD(2), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_write(b_write), .cmd_addr(b_addr), .cmd_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .nCS(b_ncs), .SCLK(b_sclk),
        .COPI(b_copi), .CIPO(b_cipo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] word;
        int          low;
        int          rises;
        int          viol;
        logic        rsp_end;
    } frame_t;

    typedef struct {
        logic        w;
        logic [6:0]  a;
        logic [7:0]  d;
        logic [7:0]  rd;
        logic [15:0] exp_word;
        logic [7:0]  exp_rd;
    } vec_t;

    frame_t      frames[$];
    logic [7:0]  rsp_q[$];
    int          gap_q[$];
    logic [7:0]  tgt_rdata = 8'h00;
    int          m_rises = 0;
    int          ready_viol = 0;
    int          b_rsp_cnt = 0;

    // Monitor of the HP=4 instance plus its CIPO target, sampled on the falling clk edge.
    initial begin
        int cyc, m_low, m_viol, fall_cnt, hi_run, last_chg, last_rise;
        logic [15:0] m_word;
        logic prev_ncs, prev_sclk, prev_copi, have_prev;
        frame_t fr;
        cyc = 0; m_low = 0; m_viol = 0; fall_cnt = 0; hi_run = 0; last_chg = 0; last_rise = 0;
        m_word = 0; prev_ncs = 1; prev_sclk = 0; prev_copi = 0; have_prev = 0;
        cipo = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (b_rsp_valid) b_rsp_cnt++;
            if (!rst_n) begin
                m_rises = 0; m_low = 0; m_viol = 0; fall_cnt = 0; hi_run = 0;
                prev_ncs = 1; prev_sclk = 0; prev_copi = 0; have_prev = 0; cipo = 1'b0;
            end else begin
                if (rsp_valid) rsp_q.push_back(rsp_rdata);
                if (!nCS) begin
                    if (prev_ncs) begin
                        if (have_prev) gap_q.push_back(hi_run);
                        m_rises = 0; m_low = 0; m_viol = 0; m_word = 0; fall_cnt = 0;
                        last_chg = cyc; last_rise = cyc - 1000; prev_copi = COPI; cipo = 1'b0;
                    end
                    m_low++;
                    if (cmd_ready) ready_viol++;
                    if (COPI != prev_copi) begin
                        if (cyc - last_rise < HP) m_viol++;
                        last_chg = cyc;
                    end
                    if (SCLK && !prev_sclk) begin
                        m_rises++;
                        m_word = {m_word[14:0], COPI};
                        if (cyc - last_chg < HP) m_viol++;
                        last_rise = cyc;
                    end
                    if (!SCLK && prev_sclk) begin
                        fall_cnt++;
                        cipo = (fall_cnt >= 8 && fall_cnt <= 15) ? tgt_rdata[15 - fall_cnt] : 1'b0;
                    end
                end else begin
                    if (!prev_ncs) begin
                        fr.word = m_word; fr.low = m_low; fr.rises = m_rises;
                        fr.viol = m_viol; fr.rsp_end = rsp_valid;
                        frames.push_back(fr);
                        have_prev = 1; hi_run = 0; cipo = 1'b0;
                    end
                    hi_run++;
                end
                prev_ncs = nCS; prev_sclk = SCLK; prev_copi = COPI;
            end
        end
    end

    // Register-file target seeing nCS/SCLK/COPI only through 2-FF synchronisers.
    logic [2:0]  s1 = 3'b100, s2 = 3'b100, s3 = 3'b100;
    logic [15:0] t_sh = 0, t_last = 0;
    int          t_n = 0, t_frames = 0;
    logic [7:0]  t_regs [0:15];
    assign b_cipo = 1'b0;

    always @(posedge clk) begin
        s1 <= {b_ncs, b_sclk, b_copi};
        s2 <= s1;
        s3 <= s2;
        if (!s2[2] && s2[1] && !s3[1]) begin
            t_sh <= {t_sh[14:0], s2[0]};
            t_n  <= t_n + 1;
        end
        if (s2[2] && !s3[2]) begin
            if (t_n == 16) begin
                t_last   <= t_sh;
                t_frames <= t_frames + 1;
                if (t_sh[15] && t_sh[14:8] <= 7'd8) t_regs[t_sh[11:8]] <= t_sh[7:0];
            end
            t_n <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        chk("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
    endtask

    task automatic get_frame(output frame_t f, output bit got);
        got = 0;
        f.word = 0; f.low = 0; f.rises = 0; f.viol = 0; f.rsp_end = 0;
        for (int t = 0; t < 2000 && frames.size() == 0; t++) begin @(negedge clk); #1; end
        if (frames.size() > 0) begin
            f = frames.pop_front();
            got = 1;
        end else begin
            checks++; failures++;
            $display("FAIL frame_timeout: got no frame expected one");
        end
    endtask

    task automatic run_frame(input string tag, input logic w, input logic [6:0] a,
                             input logic [7:0] d, input logic [7:0] rd,
                             input logic [15:0] ew, input logic [7:0] er);
        frame_t f;
        bit got;
        tgt_rdata = rd;
        issue(w, a, d);
        get_frame(f, got);
        if (got) begin
            chk({tag, "_word"}, {16'd0, f.word}, {16'd0, ew});
            chk({tag, "_ncs_low"}, f.low, 33 * HP);
            chk({tag, "_rises"}, f.rises, 16);
            chk({tag, "_copi_stable"}, f.viol, 0);
            chk({tag, "_rsp_at_end"}, {31'd0, f.rsp_end}, 32'd1);
            chk({tag, "_rsp_count"}, rsp_q.size(), 1);
            if (rsp_q.size() > 0) chk({tag, "_rdata"}, {24'd0, rsp_q.pop_front()}, {24'd0, er});
            rsp_q.delete();
        end
    endtask

    vec_t vecs[4];

    initial begin
        frame_t f1, f2;
        bit g1, g2;
        int t;
        logic w;
        logic [6:0] a;
        logic [7:0] d, rd;

        vecs[0] = '{w: 1'b1, a: 7'h04, d: 8'hA5, rd: 8'h00, exp_word: 16'h84A5, exp_rd: 8'h00};
        vecs[1] = '{w: 1'b0, a: 7'h02, d: 8'hFF, rd: 8'h3C, exp_word: 16'h0200, exp_rd: 8'h3C};
        vecs[2] = '{w: 1'b1, a: 7'h7F, d: 8'h00, rd: 8'hFF, exp_word: 16'hFF00, exp_rd: 8'hFF};
        vecs[3] = '{w: 1'b0, a: 7'h7F, d: 8'h55, rd: 8'h81, exp_word: 16'h7F00, exp_rd: 8'h81};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rst_ncs", {31'd0, nCS}, 32'd1);
        chk("rst_sclk", {31'd0, SCLK}, 32'd0);
        chk("rst_copi", {31'd0, COPI}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 4; i++)
            run_frame("vec", vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd,
                      vecs[i].exp_word, vecs[i].exp_rd);

        // Back-to-back: cmd_valid stays high across two commands.
        tgt_rdata = 8'h00;
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        ready_viol = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h05; cmd_wdata = 8'h3C;
        @(negedge clk);
        cmd_addr = 7'h06; cmd_wdata = 8'hC3;
        t = 0;
        while (!cmd_ready && t < 1000) begin @(negedge clk); t++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        get_frame(f1, g1);
        get_frame(f2, g2);
        if (g1) chk("b2b_word1", {16'd0, f1.word}, 32'h853C);
        if (g2) chk("b2b_word2", {16'd0, f2.word}, 32'h86C3);
        if (g2) chk("b2b_low2", f2.low, 33 * HP);
        chk("b2b_gap_seen", {31'd0, gap_q.size() > 0}, 32'd1);
        if (gap_q.size() > 0) chk("b2b_gap_len", gap_q[gap_q.size() - 1], GAP + 1);
        chk("b2b_ready_low_in_frame", ready_viol, 0);
        rsp_q.delete();

        // Mid-frame command changes and a cmd_valid pulse must be ignored.
        tgt_rdata = 8'h00;
        issue(1'b1, 7'h11, 8'h22);
        repeat (40) @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h7F; cmd_wdata = 8'h00;
        repeat (5) @(negedge clk);
        cmd_valid = 1'b0;
        get_frame(f1, g1);
        if (g1) chk("mid_word", {16'd0, f1.word}, 32'h9122);
        repeat (200) @(negedge clk);
        #1;
        chk("mid_no_second_frame", frames.size(), 0);
        chk("mid_ready_idle", {31'd0, cmd_ready}, 32'd1);
        rsp_q.delete();

        // Randomized frames against the frame-format rule.
        for (int i = 0; i < 20; i++) begin
            w = 1'($urandom); a = 7'($urandom); d = 8'($urandom); rd = 8'($urandom);
            run_frame("rand", w, a, d, rd, {w, a, w ? d : 8'h00}, rd);
        end
        repeat (30) @(negedge clk);
        chk("rdata_holds", {24'd0, rsp_rdata}, {24'd0, rd});

        // Asynchronous reset during bit 10.
        tgt_rdata = 8'hFF;
        issue(1'b1, 7'h2A, 8'h5A);
        t = 0;
        while (m_rises != 6 && t < 500) begin @(negedge clk); #1; t++; end
        chk("rst_mid_reached_bit10", m_rises, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ncs", {31'd0, nCS}, 32'd1);
        chk("rst_mid_sclk", {31'd0, SCLK}, 32'd0);
        chk("rst_mid_copi", {31'd0, COPI}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_mid_no_rsp", rsp_q.size(), 0);
        chk("rst_mid_no_frame", frames.size(), 0);
        run_frame("post_rst", 1'b1, 7'h00, 8'hFF, 8'h00, 16'h80FF, 8'h00);

        // HALF_PERIOD=2 against the synchronising target.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            t = 0;
            while (!b_ready && t < 1000) begin @(negedge clk); t++; end
            b_valid = 1'b1; b_write = (k == 0); b_addr = 7'h08; b_wdata = (k == 0) ? 8'h07 : 8'h99;
            @(negedge clk);
            b_valid = 1'b0; b_wdata = 8'h00;
            t = 0;
            while (t_frames != k + 1 && t < 1000) begin @(negedge clk); t++; end
            chk("hp2_frame_seen", t_frames, k + 1);
            chk("hp2_word", {16'd0, t_last}, (k == 0) ? 32'h8807 : 32'h0800);
        end
        chk("hp2_divider_reg", {24'd0, t_regs[8]}, 32'h07);
        repeat (10) @(negedge clk);
        chk("hp2_rsp_count", b_rsp_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
